// File: rtl/k_means_reg_bank.sv
// k_means_reg_bank: k-means result registers, core write port and four-phase host read port.
// Define KMEANS_REG_PARITY_EN to store an even-parity bit per register and flag mismatches on read.
module k_means_reg_bank #(
   parameter int addrWidth = 8,
   parameter int dataWidth = 91,
   parameter int NUM_REGS  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [addrWidth-1:0] reg_num,
   input  logic                 reg_w_r,
   input  logic [dataWidth-1:0] reg_write_data,
   input  logic                 interupt,
   input  logic                 host_rd_req,
   input  logic [addrWidth-1:0] host_rd_addr,
   output logic                 host_rd_ack,
   output logic [dataWidth-1:0] host_rd_data,
   output logic                 host_irq,
   input  logic                 host_irq_clr,
   output logic                 wr_err,
   output logic                 rd_err
);
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [addrWidth:0] NR = (addrWidth + 1)'(NUM_REGS);
   typedef enum logic [1:0] {IDLE, READ, ACK} state_t;
   state_t               state_q, state_d;
   logic [dataWidth-1:0] regs_q [NUM_REGS];
   logic [addrWidth-1:0] addr_q, addr_d;
   logic [dataWidth-1:0] rd_data_q, rd_data_d;
   logic                 rd_err_q, rd_err_d, irq_q, irq_d, wr_err_q, wr_err_d, block_q, block_d;
   logic                 wr_ok, rd_ok, accept, par_bad;
   logic [IW-1:0]        wr_idx, rd_idx;
   assign wr_ok  = {1'b0, reg_num} < NR;
   assign rd_ok  = {1'b0, addr_q} < NR;
   assign wr_idx = reg_num[IW-1:0];
   assign rd_idx = addr_q[IW-1:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (reg_w_r && wr_ok) begin
         regs_q[wr_idx] <= reg_write_data;
      end
`ifdef KMEANS_REG_PARITY_EN
   logic [NUM_REGS-1:0] par_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) par_q <= '0;
      else if (reg_w_r && wr_ok) par_q[wr_idx] <= ^reg_write_data;
   assign par_bad = (^regs_q[rd_idx]) != par_q[rd_idx];
`else
   assign par_bad = 1'b0;
`endif
   // block_q holds off new reads after reset until the host has dropped its request
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rd_data_q <= '0;
         rd_err_q  <= 1'b0;
         irq_q     <= 1'b0;
         wr_err_q  <= 1'b0;
         block_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
         irq_q     <= irq_d;
         wr_err_q  <= wr_err_d;
         block_q   <= block_d;
      end
   always_comb begin
      state_d = (state_q == IDLE) ? (accept ? READ : IDLE)
              : (state_q == READ) ? ACK
              : (host_rd_req ? ACK : IDLE);
   end
   // Read data is taken from the register array before this edge's write lands
   always_comb begin
      accept    = (state_q == IDLE) && host_rd_req && !block_q;
      addr_d    = accept ? host_rd_addr : addr_q;
      rd_data_d = (state_q == READ) ? (rd_ok ? regs_q[rd_idx] : '0) : rd_data_q;
      rd_err_d  = (state_q == READ) ? (!rd_ok || par_bad) : rd_err_q;
      block_d   = block_q && host_rd_req;
      irq_d     = interupt || (irq_q && !host_irq_clr);
      wr_err_d  = (reg_w_r && !wr_ok) || (wr_err_q && !host_irq_clr);
   end
   always_comb begin
      host_rd_ack  = (state_q == ACK);
      host_rd_data = rd_data_q;
      rd_err       = rd_err_q;
      host_irq     = irq_q;
      wr_err       = wr_err_q;
   end
endmodule

// File: tb/tb_k_means_reg_bank.sv
// tb_k_means_reg_bank: randomized and directed checks of k_means_reg_bank against an array model.
module tb_k_means_reg_bank;
   localparam int AW = 8, DW = 91, NR = 16;
   logic clk = 1'b0, rst_n, reg_w_r, interupt, host_rd_req, host_irq_clr;
   logic host_rd_ack, host_irq, wr_err, rd_err;
   logic [AW-1:0] reg_num, host_rd_addr;
   logic [DW-1:0] reg_write_data, host_rd_data;
   int checks = 0, errors = 0;
   logic [DW-1:0] model [NR];
   logic m_irq, m_wr_err;

   k_means_reg_bank #(.addrWidth(AW), .dataWidth(DW), .NUM_REGS(NR)) dut (
      .clk(clk), .rst_n(rst_n), .reg_num(reg_num), .reg_w_r(reg_w_r),
      .reg_write_data(reg_write_data), .interupt(interupt), .host_rd_req(host_rd_req),
      .host_rd_addr(host_rd_addr), .host_rd_ack(host_rd_ack), .host_rd_data(host_rd_data),
      .host_irq(host_irq), .host_irq_clr(host_irq_clr), .wr_err(wr_err), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      for (int i = 0; i < NR; i++) model[i] = '0;
      m_irq = 1'b0;
      m_wr_err = 1'b0;
   endtask

   function automatic logic [DW-1:0] rnd_data;
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] exp_data(input int a);
      return (a < NR) ? model[a] : '0;
   endfunction

   task automatic core_write(input int idx, input logic [DW-1:0] d);
      reg_num = AW'(idx);
      reg_write_data = d;
      reg_w_r = 1'b1;
      tick();
      reg_w_r = 1'b0;
      if (idx < NR) model[idx] = d;
      else m_wr_err = 1'b1;
   endtask

   task automatic start_read(input int idx);
      host_rd_addr = AW'(idx);
      host_rd_req = 1'b1;
      tick();
      tick();
   endtask

   task automatic end_read;
      host_rd_req = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      rst_n = 1'b0; reg_w_r = 1'b0; interupt = 1'b0; host_rd_req = 1'b0; host_irq_clr = 1'b0;
      reg_num = '0; host_rd_addr = '0; reg_write_data = '0;
      model_reset();
      #12;
      checks++; if (host_rd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", host_rd_ack); end
      checks++; if (host_rd_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", host_rd_data); end
      checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err got %b want 0", rd_err); end
      checks++; if (host_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", host_irq); end
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_read;
      core_write(3, 91'h5A5);
      host_rd_addr = 8'd3;
      host_rd_req = 1'b1;
      tick();
      checks++; if (host_rd_ack !== 1'b0) begin errors++; $display("FAIL latency_early_ack got %b want 0", host_rd_ack); end
      tick();
      checks++; if (host_rd_ack !== 1'b1) begin errors++; $display("FAIL latency_ack got %b want 1", host_rd_ack); end
      checks++; if (host_rd_data !== 91'h5A5) begin errors++; $display("FAIL idx3_data got %h want %h", host_rd_data, 91'h5A5); end
      checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL idx3_rd_err got %b want 0", rd_err); end
      end_read();
      checks++; if (host_rd_ack !== 1'b0) begin errors++; $display("FAIL ack_drop got %b want 0", host_rd_ack); end
   endtask

   task automatic test_out_of_range;
      core_write(20, rnd_data());
      checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL oob_wr_err got %b want 1", wr_err); end
      start_read(20);
      checks++; if (host_rd_data !== '0 || rd_err !== 1'b1) begin errors++; $display("FAIL oob_read got data %h err %b want 0 err 1", host_rd_data, rd_err); end
      end_read();
      start_read(4);
      checks++; if (host_rd_data !== model[4] || rd_err !== 1'b0) begin errors++; $display("FAIL oob_storage got %h err %b want %h err 0", host_rd_data, rd_err, model[4]); end
      end_read();
      host_irq_clr = 1'b1;
      tick();
      host_irq_clr = 1'b0;
      m_wr_err = 1'b0;
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_clear got %b want 0", wr_err); end
   endtask

   task automatic test_read_during_write;
      core_write(5, 91'h1);
      host_rd_addr = 8'd5;
      host_rd_req = 1'b1;
      tick();
      reg_num = 8'd5; reg_write_data = 91'h2; reg_w_r = 1'b1;
      tick();
      reg_w_r = 1'b0;
      model[5] = 91'h2;
      checks++; if (host_rd_data !== 91'h1) begin errors++; $display("FAIL rw_same_edge got %h want 1", host_rd_data); end
      end_read();
      start_read(5);
      checks++; if (host_rd_data !== 91'h2) begin errors++; $display("FAIL rw_second_read got %h want 2", host_rd_data); end
      end_read();
   endtask

   task automatic test_irq;
      interupt = 1'b1;
      tick();
      interupt = 1'b0;
      checks++; if (host_irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", host_irq); end
      interupt = 1'b1; host_irq_clr = 1'b1;
      tick();
      interupt = 1'b0;
      checks++; if (host_irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b want 1", host_irq); end
      tick();
      host_irq_clr = 1'b0;
      checks++; if (host_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", host_irq); end
      reg_num = 8'd30; reg_w_r = 1'b1; host_irq_clr = 1'b1;
      tick();
      reg_w_r = 1'b0; host_irq_clr = 1'b0;
      checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_set_wins got %b want 1", wr_err); end
      host_irq_clr = 1'b1;
      tick();
      host_irq_clr = 1'b0;
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_clear2 got %b want 0", wr_err); end
      m_irq = 1'b0; m_wr_err = 1'b0;
   endtask

   task automatic test_hold_and_reset;
      logic [DW-1:0] held;
      core_write(9, rnd_data());
      held = model[9];
      start_read(9);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            reg_num = 8'd9; reg_write_data = ~held; reg_w_r = 1'b1;
         end
         tick();
         reg_w_r = 1'b0;
         checks++; if (host_rd_ack !== 1'b1 || host_rd_data !== held) begin errors++; $display("FAIL hold_c%0d got ack %b data %h want ack 1 data %h", c, host_rd_ack, host_rd_data, held); end
      end
      model[9] = ~held;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (host_rd_ack !== 1'b0 || host_rd_data !== '0) begin errors++; $display("FAIL async_reset got ack %b data %h want 0 0", host_rd_ack, host_rd_data); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (host_rd_ack !== 1'b0) begin errors++; $display("FAIL post_reset_block_c%0d got %b want 0", c, host_rd_ack); end
      end
      end_read();
      start_read(9);
      checks++; if (host_rd_ack !== 1'b1 || host_rd_data !== model[9]) begin errors++; $display("FAIL post_reset_read got ack %b data %h want 1 %h", host_rd_ack, host_rd_data, model[9]); end
      end_read();
   endtask

`ifdef KMEANS_REG_PARITY_EN
   task automatic test_parity;
      core_write(7, rnd_data());
      dut.regs_q[7][0] = ~dut.regs_q[7][0];
      model[7][0] = ~model[7][0];
      start_read(7);
      checks++; if (host_rd_data !== model[7] || rd_err !== 1'b1) begin errors++; $display("FAIL parity got %h err %b want %h err 1", host_rd_data, rd_err, model[7]); end
      end_read();
      core_write(7, rnd_data());
   endtask
`endif

   task automatic test_random;
      int op, a;
      for (int n = 0; n < 80; n++) begin
         op = $urandom_range(0, 2);
         a = $urandom_range(0, 23);
         if (op == 0) begin
            core_write(a, rnd_data());
            checks++; if (wr_err !== m_wr_err) begin errors++; $display("FAIL rnd_wr_err n%0d got %b want %b", n, wr_err, m_wr_err); end
         end else if (op == 1) begin
            start_read(a);
            checks++; if (host_rd_ack !== 1'b1 || host_rd_data !== exp_data(a) || rd_err !== (a >= NR)) begin errors++; $display("FAIL rnd_read n%0d idx %0d got ack %b data %h err %b want %h", n, a, host_rd_ack, host_rd_data, rd_err, exp_data(a)); end
            end_read();
         end else begin
            interupt = 1'($urandom_range(0, 1));
            host_irq_clr = 1'($urandom_range(0, 1));
            tick();
            m_irq = interupt | (m_irq & ~host_irq_clr);
            m_wr_err = m_wr_err & ~host_irq_clr;
            interupt = 1'b0; host_irq_clr = 1'b0;
            checks++; if (host_irq !== m_irq || wr_err !== m_wr_err) begin errors++; $display("FAIL rnd_irq n%0d got irq %b wr_err %b want %b %b", n, host_irq, wr_err, m_irq, m_wr_err); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_read_during_write();
      test_irq();
      test_hold_and_reset();
`ifdef KMEANS_REG_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
